// File: rtl/crc16_pkg.sv
// Shared constants for the Gen2 CRC-16 datapath and the surrounding framer.
package crc16_pkg;
    localparam logic [15:0] CRC16_POLY    = 16'h1021;
    localparam logic [15:0] CRC16_PRESET  = 16'hFFFF;
    localparam logic [15:0] CRC16_RESIDUE = 16'h1D0F;
    // Gen2 reader preamble pattern, consumed by the framer ahead of this engine.
    localparam logic [11:0] GEN2_PREAMBLE = 12'b110100100011;
endpackage

// File: rtl/crc16_frame_engine_if.sv
// Beat stream into the CRC engine and its CRC/status outputs.
interface crc16_frame_engine_if #(parameter int NUM_BITS = 1);
    logic                clear;
    logic                in_valid;
    logic [NUM_BITS-1:0] in_data;
    logic                in_last;
    logic [15:0]         crc_reg;
    logic [15:0]         crc_out;
    logic                done;
    logic                crc_ok;

    modport master (output clear, in_valid, in_data, in_last,
                    input  crc_reg, crc_out, done, crc_ok);
    modport slave  (input  clear, in_valid, in_data, in_last,
                    output crc_reg, crc_out, done, crc_ok);
endinterface

// File: rtl/crc16_step.sv
// Combinational NUM_BITS-step CRC-16 advance; dat[NUM_BITS-1] is shifted in first.
module crc16_step
    import crc16_pkg::*;
#(
    parameter int NUM_BITS = 1
) (
    input  logic [NUM_BITS-1:0] dat,
    input  logic [15:0]         crc_in,
    output logic [15:0]         crc_next
);
    logic [15:0] w_crc;
    logic        w_fb;

    always_comb begin
        w_crc = crc_in;
        w_fb  = 1'b0;
        for (int i = NUM_BITS - 1; i >= 0; i--) begin
            w_fb  = w_crc[15] ^ dat[i];
            w_crc = {w_crc[14:0], 1'b0} ^ (w_fb ? CRC16_POLY : 16'h0000);
        end
        crc_next = w_crc;
    end
endmodule

// File: rtl/crc16_frame_engine.sv
// Frame-level CRC-16 engine: running CRC for transmit, residue check for receive.
module crc16_frame_engine
    import crc16_pkg::*;
#(
    parameter int          NUM_BITS = 1,
    parameter logic [15:0] RESIDUE  = CRC16_RESIDUE
) (
    input logic                  sys_clk,
    input logic                  rst,
    crc16_frame_engine_if.slave  bus
);
    logic [15:0] r_crc;
    logic        r_done;
    logic        r_ok;
    logic [15:0] w_base;
    logic [15:0] w_next;
    logic        w_end;

    // clear folds the preset into the same cycle so the first beat is not lost
    assign w_base = bus.clear ? CRC16_PRESET : r_crc;
    assign w_end  = bus.in_valid & bus.in_last;

    crc16_step #(.NUM_BITS(NUM_BITS)) u_step (
        .dat      (bus.in_data),
        .crc_in   (w_base),
        .crc_next (w_next)
    );

    always_ff @(posedge sys_clk) begin
        if (rst) begin
            r_crc  <= CRC16_PRESET;
            r_done <= 1'b0;
            r_ok   <= 1'b0;
        end else begin
            if (bus.in_valid)
                r_crc <= w_next;
            else if (bus.clear)
                r_crc <= CRC16_PRESET;
            r_done <= w_end;
            r_ok   <= w_end && (w_next == RESIDUE);
        end
    end

    assign bus.crc_reg = r_crc;
    assign bus.crc_out = ~r_crc;
    assign bus.done    = r_done;
    assign bus.crc_ok  = r_ok;
endmodule

// File: tb/tb_crc16_frame_engine.sv
// Bench for crc16_frame_engine at NUM_BITS = 1, 8 and 16 against a bit-serial reference.
module tb_crc16_frame_engine;
    logic clk = 1'b0;
    logic rst;
    int   errors = 0;
    int   checks = 0;
    logic [7:0] msg [9];

    always #5 clk = ~clk;

    crc16_frame_engine_if #(.NUM_BITS(8))  bus8 ();
    crc16_frame_engine_if #(.NUM_BITS(1))  bus1 ();
    crc16_frame_engine_if #(.NUM_BITS(16)) bus16 ();

    crc16_frame_engine #(.NUM_BITS(8))  u8  (.sys_clk(clk), .rst(rst), .bus(bus8.slave));
    crc16_frame_engine #(.NUM_BITS(1))  u1  (.sys_clk(clk), .rst(rst), .bus(bus1.slave));
    crc16_frame_engine #(.NUM_BITS(16)) u16 (.sys_clk(clk), .rst(rst), .bus(bus16.slave));

    // Reference: polynomial division of the bit list, preset 0xFFFF, MSB first.
    function automatic logic [15:0] model_crc(input bit bits[$]);
        int r = 'hFFFF;
        foreach (bits[k]) begin
            int fb = ((r >> 15) & 1) ^ int'(bits[k]);
            r = (r << 1) & 'hFFFF;
            if (fb != 0) r = r ^ 'h1021;
        end
        return r[15:0];
    endfunction

    task automatic send8(input logic [7:0] d, input logic clr, input logic last);
        bus8.clear = clr; bus8.in_valid = 1'b1; bus8.in_data = d; bus8.in_last = last;
        @(negedge clk);
        bus8.clear = 1'b0; bus8.in_valid = 1'b0; bus8.in_last = 1'b0;
    endtask

    task automatic send1(input logic d, input logic clr, input logic last);
        bus1.clear = clr; bus1.in_valid = 1'b1; bus1.in_data = d; bus1.in_last = last;
        @(negedge clk);
        bus1.clear = 1'b0; bus1.in_valid = 1'b0; bus1.in_last = 1'b0;
    endtask

    task automatic send16(input logic [15:0] d, input logic clr, input logic last);
        bus16.clear = clr; bus16.in_valid = 1'b1; bus16.in_data = d; bus16.in_last = last;
        @(negedge clk);
        bus16.clear = 1'b0; bus16.in_valid = 1'b0; bus16.in_last = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++; if (bus8.crc_reg !== 16'hFFFF) begin errors++; $display("FAIL reset_reg8: got %h expected ffff", bus8.crc_reg); end
        checks++; if (bus8.crc_out !== 16'h0000) begin errors++; $display("FAIL reset_out8: got %h expected 0000", bus8.crc_out); end
        checks++; if (bus8.done !== 1'b0 || bus8.crc_ok !== 1'b0) begin errors++; $display("FAIL reset_flags8: got done=%b ok=%b expected 0 0", bus8.done, bus8.crc_ok); end
        checks++; if (bus1.crc_reg !== 16'hFFFF || bus16.crc_reg !== 16'hFFFF) begin errors++; $display("FAIL reset_reg1_16: got %h %h expected ffff", bus1.crc_reg, bus16.crc_reg); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_vector8();
        for (int i = 0; i < 9; i++) send8(msg[i], i == 0, i == 8);
        checks++; if (bus8.crc_reg !== 16'h29B1) begin errors++; $display("FAIL vec8_reg: got %h expected 29b1", bus8.crc_reg); end
        checks++; if (bus8.crc_out !== 16'hD64E) begin errors++; $display("FAIL vec8_out: got %h expected d64e", bus8.crc_out); end
        checks++; if (bus8.done !== 1'b1 || bus8.crc_ok !== 1'b0) begin errors++; $display("FAIL vec8_flags: got done=%b ok=%b expected 1 0", bus8.done, bus8.crc_ok); end
        @(negedge clk);
        checks++; if (bus8.done !== 1'b0 || bus8.crc_reg !== 16'h29B1) begin errors++; $display("FAIL vec8_hold: got done=%b reg=%h expected 0 29b1", bus8.done, bus8.crc_reg); end
    endtask

    task automatic test_residue8();
        bit q[$];
        logic [15:0] exp;
        for (int i = 0; i < 9; i++) send8(msg[i], i == 0, 1'b0);
        send8(8'hD6, 1'b0, 1'b0);
        send8(8'h4E, 1'b0, 1'b1);
        checks++; if (bus8.done !== 1'b1 || bus8.crc_ok !== 1'b1) begin errors++; $display("FAIL res8_flags: got done=%b ok=%b expected 1 1", bus8.done, bus8.crc_ok); end
        checks++; if (bus8.crc_reg !== 16'h1D0F) begin errors++; $display("FAIL res8_reg: got %h expected 1d0f", bus8.crc_reg); end
        @(negedge clk);
        checks++; if (bus8.done !== 1'b0 || bus8.crc_ok !== 1'b0) begin errors++; $display("FAIL res8_pulse: got done=%b ok=%b expected 0 0", bus8.done, bus8.crc_ok); end
        // one flipped payload bit must break the residue
        for (int i = 0; i < 9; i++) begin
            logic [7:0] b = (i == 4) ? (msg[i] ^ 8'h04) : msg[i];
            for (int j = 7; j >= 0; j--) q.push_back(b[j]);
            send8(b, i == 0, 1'b0);
        end
        send8(8'hD6, 1'b0, 1'b0);
        send8(8'h4E, 1'b0, 1'b1);
        for (int j = 7; j >= 0; j--) q.push_back(bit'((8'hD6 >> j) & 1));
        for (int j = 7; j >= 0; j--) q.push_back(bit'((8'h4E >> j) & 1));
        exp = model_crc(q);
        checks++; if (bus8.done !== 1'b1 || bus8.crc_ok !== 1'b0) begin errors++; $display("FAIL flip8_flags: got done=%b ok=%b expected 1 0", bus8.done, bus8.crc_ok); end
        checks++; if (bus8.crc_reg !== exp) begin errors++; $display("FAIL flip8_reg: got %h expected %h", bus8.crc_reg, exp); end
    endtask

    task automatic test_nb1();
        bit q[$];
        for (int i = 0; i < 9; i++)
            for (int j = 7; j >= 0; j--) q.push_back(msg[i][j]);
        for (int j = 15; j >= 0; j--) q.push_back(bit'((16'hD64E >> j) & 1));
        for (int k = 0; k < 88; k++) begin
            send1(q[k], k == 0, k == 87);
            if (k == 71) begin
                checks++; if (bus1.crc_out !== 16'hD64E) begin errors++; $display("FAIL nb1_out: got %h expected d64e", bus1.crc_out); end
            end
        end
        checks++; if (bus1.done !== 1'b1 || bus1.crc_ok !== 1'b1) begin errors++; $display("FAIL nb1_flags: got done=%b ok=%b expected 1 1", bus1.done, bus1.crc_ok); end
        checks++; if (bus1.crc_reg !== 16'h1D0F) begin errors++; $display("FAIL nb1_reg: got %h expected 1d0f", bus1.crc_reg); end
    endtask

    task automatic test_nb16();
        bit q[$];
        logic [15:0] w [5];
        logic [15:0] exp;
        for (int i = 0; i < 5; i++) begin
            w[i] = {msg[2*i], (i == 4) ? 8'h00 : msg[2*i+1]};
            for (int j = 15; j >= 0; j--) q.push_back(w[i][j]);
        end
        exp = model_crc(q);
        for (int i = 0; i < 5; i++) send16(w[i], i == 0, 1'b0);
        checks++; if (bus16.crc_out !== ~exp) begin errors++; $display("FAIL nb16_out: got %h expected %h", bus16.crc_out, ~exp); end
        checks++; if (bus16.done !== 1'b0) begin errors++; $display("FAIL nb16_nodone: got %b expected 0", bus16.done); end
        send16(~exp, 1'b0, 1'b1);
        checks++; if (bus16.done !== 1'b1 || bus16.crc_ok !== 1'b1) begin errors++; $display("FAIL nb16_flags: got done=%b ok=%b expected 1 1", bus16.done, bus16.crc_ok); end
        checks++; if (bus16.crc_reg !== 16'h1D0F) begin errors++; $display("FAIL nb16_reg: got %h expected 1d0f", bus16.crc_reg); end
    endtask

    task automatic test_random1();
        for (int f = 0; f < 8; f++) begin
            bit q[$];
            logic [15:0] exp;
            int len = $urandom_range(200, 10);
            for (int k = 0; k < len; k++) q.push_back(bit'($urandom_range(1, 0)));
            exp = ~model_crc(q);
            for (int k = 0; k < len; k++) begin
                send1(q[k], k == 0, 1'b0);
                if ($urandom_range(3, 0) == 0) begin
                    // idle beats carry junk that must be ignored
                    bus1.in_data = 1'($urandom); bus1.in_last = 1'($urandom);
                    repeat ($urandom_range(2, 1)) @(negedge clk);
                    bus1.in_last = 1'b0;
                end
            end
            checks++; if (bus1.crc_out !== exp || bus1.done !== 1'b0) begin errors++; $display("FAIL rnd_out[%0d]: got %h done=%b expected %h done=0", f, bus1.crc_out, bus1.done, exp); end
            for (int j = 15; j >= 0; j--) send1(exp[j], 1'b0, j == 0);
            checks++; if (bus1.done !== 1'b1 || bus1.crc_ok !== 1'b1 || bus1.crc_reg !== 16'h1D0F) begin errors++; $display("FAIL rnd_ok[%0d]: got done=%b ok=%b reg=%h expected 1 1 1d0f", f, bus1.done, bus1.crc_ok, bus1.crc_reg); end
        end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 5; i++) send8(msg[i], i == 0, 1'b0);
        rst = 1'b1;
        bus8.in_valid = 1'b1; bus8.in_data = 8'h55; bus8.in_last = 1'b1;
        @(negedge clk);
        rst = 1'b0; bus8.in_valid = 1'b0; bus8.in_last = 1'b0;
        checks++; if (bus8.done !== 1'b0 || bus8.crc_reg !== 16'hFFFF) begin errors++; $display("FAIL rstmid_abort: got done=%b reg=%h expected 0 ffff", bus8.done, bus8.crc_reg); end
        @(negedge clk);
        checks++; if (bus8.done !== 1'b0) begin errors++; $display("FAIL rstmid_nodone: got %b expected 0", bus8.done); end
        send8(8'h00, 1'b0, 1'b1);
        checks++; if (bus8.crc_reg !== 16'hE1F0) begin errors++; $display("FAIL rstmid_reg: got %h expected e1f0", bus8.crc_reg); end
        checks++; if (bus8.done !== 1'b1 || bus8.crc_ok !== 1'b0) begin errors++; $display("FAIL rstmid_flags: got done=%b ok=%b expected 1 0", bus8.done, bus8.crc_ok); end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 9; i++) send8(msg[i], i == 0, 1'b0);
        send8(8'hD6, 1'b0, 1'b0);
        send8(8'h4E, 1'b0, 1'b1);
        checks++; if (bus8.done !== 1'b1 || bus8.crc_ok !== 1'b1) begin errors++; $display("FAIL b2b_a: got done=%b ok=%b expected 1 1", bus8.done, bus8.crc_ok); end
        // single-beat frame with clear, issued while frame A's done is up
        send8(8'h00, 1'b1, 1'b1);
        checks++; if (bus8.done !== 1'b1 || bus8.crc_ok !== 1'b0 || bus8.crc_reg !== 16'hE1F0) begin errors++; $display("FAIL b2b_b: got done=%b ok=%b reg=%h expected 1 0 e1f0", bus8.done, bus8.crc_ok, bus8.crc_reg); end
        for (int i = 0; i < 9; i++) begin
            send8(msg[i], i == 0, i == 8);
            if (i == 0) begin
                checks++; if (bus8.done !== 1'b0) begin errors++; $display("FAIL b2b_c_pulse: got %b expected 0", bus8.done); end
            end
        end
        checks++; if (bus8.crc_reg !== 16'h29B1 || bus8.done !== 1'b1 || bus8.crc_ok !== 1'b0) begin errors++; $display("FAIL b2b_c: got reg=%h done=%b ok=%b expected 29b1 1 0", bus8.crc_reg, bus8.done, bus8.crc_ok); end
    endtask

    initial begin
        for (int i = 0; i < 9; i++) msg[i] = 8'h31 + 8'(i);
        rst = 1'b1;
        bus8.clear = 1'b0;  bus8.in_valid = 1'b0;  bus8.in_data = '0;  bus8.in_last = 1'b0;
        bus1.clear = 1'b0;  bus1.in_valid = 1'b0;  bus1.in_data = '0;  bus1.in_last = 1'b0;
        bus16.clear = 1'b0; bus16.in_valid = 1'b0; bus16.in_data = '0; bus16.in_last = 1'b0;
        @(negedge clk);
        test_reset();
        test_vector8();
        test_residue8();
        test_nb1();
        test_nb16();
        test_random1();
        test_reset_mid();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/crc16_frame_engine.md
Name: crc16_frame_engine

Overview:
Clocked CRC-16 engine for the RFID reader receive/transmit paths. It uses the EPC Gen2 CRC-16: polynomial x^16+x^12+x^5+1 (0x1021), preset 0xFFFF, MSB-first, non-reflected, ones-complement output.
- Accepts a frame as a stream of NUM_BITS-wide beats.
- Produces the running CRC to append on transmit.
- Flags residue-correct frames on receive (data followed by its CRC).
- Sits after the bit decoder / before the UART-LED reporting logic in top-level integration.

Parameters:
NUM_BITS, 1, bits consumed per valid beat (legal 1..16); in_data[NUM_BITS-1] is the earliest bit on air.
RESIDUE, 16'h1D0F, register value indicating a good frame after data+CRC are shifted in.

Ports:
sys_clk  in  1  system clock, all state on rising edge
rst  in  1  synchronous active-high reset
clear  in  1  start of frame; reloads register with 0xFFFF
in_valid  in  1  in_data beat is valid this cycle
in_data  in  NUM_BITS  data bits, MSB first
in_last  in  1  qualifies final beat of frame (ignored when in_valid=0)
crc_reg  out  16  raw CRC shift register
crc_out  out  16  ~crc_reg (value to transmit, MSB first)
done  out  1  one-cycle pulse after the last beat is absorbed
crc_ok  out  1  valid while done=1: crc_reg == RESIDUE

Behaviour:
- Reset: crc_reg=0xFFFF, crc_out=0x0000, done=0, crc_ok=0. Reset mid-frame discards the frame; no done is produced for it.
- Single-bit step, for input bit b: fb = crc_reg[15]^b. The next register is {crc_reg[14:0],1'b0}, XOR 0x1021 if fb=1.
- A beat applies the step NUM_BITS times in order in_data[NUM_BITS-1] down to in_data[0]. This is purely combinational inside one cycle.
- Register update on each edge, in priority order:
  - rst: reload 0xFFFF.
  - clear & in_valid: crc_reg <= step(0xFFFF, in_data). The clear and the first beat are accepted in the same cycle.
  - clear alone: reload 0xFFFF.
  - in_valid: crc_reg <= step(crc_reg, in_data).
  - Otherwise: hold.
- crc_out is combinational from crc_reg. Zero latency after the edge that absorbs a beat.
- done: registered. It is 1 in the cycle after the edge where in_valid & in_last was accepted; otherwise 0.
- crc_ok: registered in the same edge as done. It compares the post-update register value with RESIDUE. It is 0 whenever done=0.
- Frames must be a whole number of NUM_BITS beats; no partial-beat support. Frame lengths are unbounded; the register simply keeps rolling.
- Back-to-back frames: clear may coincide with the cycle in which done is asserted. done and crc_ok still report the previous frame.
- in_valid with no preceding clear continues from the current register (after reset this equals 0xFFFF).

Decomposition:
- Shared package crc16_pkg:
  - CRC16_POLY=16'h1021, CRC16_PRESET=16'hFFFF, CRC16_RESIDUE=16'h1D0F.
  - Gen2 preamble constant 12'b110100100011 for the surrounding framer.
- One natural combinational sub-module, crc16_step. Parameter NUM_BITS; ports dat[NUM_BITS-1:0], crc_in[15:0], crc_next[15:0]; a loop over NUM_BITS single-bit steps. The engine instantiates it once.

Test Plan:
- ASCII "123456789", NUM_BITS=8: clear, then 9 beats with the last marked -> crc_out=0xD64E, crc_reg=0x29B1 after the final beat.
- Same bytes, then beats 0xD6, 0x4E with in_last on 0x4E -> done pulse one cycle later, crc_ok=1, crc_reg=0x1D0F. Flip one data bit -> crc_ok=0.
- Repeat the above with NUM_BITS=1 (72+16 beats, MSB first) and NUM_BITS=16 (padded payload 0x3132..., fixed vector cross-checked against crc16_step model) -> identical results to NUM_BITS=8.
- Random payload lengths 10..200 bits, NUM_BITS=1, random in_valid gaps -> crc_out matches software model; appended CRC always gives crc_ok=1.
- Assert rst mid-frame after 5 bytes, then in_valid+in_last without clear on byte 0x00 -> no done for aborted frame; crc_reg=step(0xFFFF,0x00)=0xE1F0.
- clear coincident with first beat, and clear in the same cycle as the previous frame's done -> first beat not lost; previous crc_ok reported correctly.
